// File: rtl/compressor_scheduler.sv
// Shared-compressor scheduler for a fridge/freezer pair: demand latches with hysteresis,
// arbitration, minimum on/off times, a maximum run per compartment and periodic defrost.
module compressor_scheduler #(
    parameter int MIN_ON           = 4,
    parameter int MIN_OFF          = 3,
    parameter int MAX_RUN          = 8,
    parameter int HYST             = 2,
    parameter int DEFROST_INTERVAL = 20,
    parameter int DEFROST_LEN      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pwr,
    input  logic       i_fgp,
    input  logic       i_frp,
    input  logic [4:0] i_fgt,
    input  logic [4:0] i_frt,
    input  logic [4:0] i_fg_sense,
    input  logic [4:0] i_fr_sense,
    output logic       o_comp_on,
    output logic       o_damper,
    output logic       o_heater_on,
    output logic       o_fg_dem,
    output logic       o_fr_dem,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COOL_FG  = 3'd1,
        COOL_FR  = 3'd2,
        OFF_HOLD = 3'd3,
        DEFROST  = 3'd4
    } state_t;

    localparam int TMR_MAX = (MIN_OFF > DEFROST_LEN) ? MIN_OFF : DEFROST_LEN;
    localparam int RUN_W   = $clog2(MIN_ON + 1);
    localparam int SEG_W   = $clog2(MAX_RUN + 1);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DFR_W   = $clog2(DEFROST_INTERVAL + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_ON - 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(MAX_RUN - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(MIN_OFF - 1);
    localparam logic [TMR_W-1:0] DFR_LAST = TMR_W'(DEFROST_LEN - 1);
    localparam logic [DFR_W-1:0] DFR_FULL = DFR_W'(DEFROST_INTERVAL);

    state_t           r_state;
    logic             r_fg_dem;
    logic             r_fr_dem;
    logic             r_last_fr;
    logic [RUN_W-1:0] r_run_cnt;
    logic [SEG_W-1:0] r_seg_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic [DFR_W-1:0] r_dfr_acc;

    state_t           w_state_nxt;
    logic             w_fg_dem_nxt;
    logic             w_fr_dem_nxt;
    logic             w_last_fr_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [SEG_W-1:0] w_seg_nxt;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic [DFR_W-1:0] w_dfr_nxt;
    logic             w_x_dem;
    logic             w_o_dem;
    logic             w_in_fr;
    logic [5:0]       w_fg_thr;
    logic [5:0]       w_fr_thr;

    // Thresholds are 6 bits wide so a setpoint near 31 cannot wrap into a low value.
    assign w_fg_thr = {1'b0, i_fgt} + 6'(HYST);
    assign w_fr_thr = {1'b0, i_frt} + 6'(HYST);

    always_comb begin
        w_fg_dem_nxt = r_fg_dem;
        w_fr_dem_nxt = r_fr_dem;
        if (!i_pwr) begin
            w_fg_dem_nxt = 1'b0;
            w_fr_dem_nxt = 1'b0;
        end else begin
            if (i_fgp && ({1'b0, i_fg_sense} > w_fg_thr))
                w_fg_dem_nxt = 1'b1;
            else if (!i_fgp || (i_fg_sense <= i_fgt))
                w_fg_dem_nxt = 1'b0;
            if (i_frp && ({1'b0, i_fr_sense} > w_fr_thr))
                w_fr_dem_nxt = 1'b1;
            else if (!i_frp || (i_fr_sense <= i_frt))
                w_fr_dem_nxt = 1'b0;
        end
    end

    assign w_in_fr = (r_state == COOL_FR);
    assign w_x_dem = w_in_fr ? r_fr_dem : r_fg_dem;
    assign w_o_dem = w_in_fr ? r_fg_dem : r_fr_dem;

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_fr_nxt = r_last_fr;
        w_run_nxt     = r_run_cnt;
        w_seg_nxt     = r_seg_cnt;
        w_tmr_nxt     = r_tmr;
        w_dfr_nxt     = r_dfr_acc;

        unique case (r_state)
            IDLE: begin
                if (r_fg_dem || r_fr_dem) begin
                    if (r_fg_dem && r_fr_dem)
                        w_state_nxt = r_last_fr ? COOL_FG : COOL_FR;
                    else
                        w_state_nxt = r_fr_dem ? COOL_FR : COOL_FG;
                    w_run_nxt = '0;
                    w_seg_nxt = '0;
                end
            end
            COOL_FG, COOL_FR: begin
                w_run_nxt = (r_run_cnt == RUN_LAST) ? r_run_cnt : r_run_cnt + RUN_W'(1);
                w_seg_nxt = (r_seg_cnt == SEG_LAST) ? r_seg_cnt : r_seg_cnt + SEG_W'(1);
                w_dfr_nxt = (r_dfr_acc == DFR_FULL) ? r_dfr_acc : r_dfr_acc + DFR_W'(1);
                if (w_o_dem && (!w_x_dem || (r_seg_cnt == SEG_LAST))) begin
                    w_state_nxt   = w_in_fr ? COOL_FG : COOL_FR;
                    w_seg_nxt     = '0;
                    w_last_fr_nxt = w_in_fr;
                end else if (!w_x_dem && !w_o_dem && (r_run_cnt == RUN_LAST)) begin
                    w_state_nxt   = (r_dfr_acc == DFR_FULL) ? DEFROST : OFF_HOLD;
                    w_run_nxt     = '0;
                    w_seg_nxt     = '0;
                    w_tmr_nxt     = '0;
                    w_last_fr_nxt = w_in_fr;
                end
            end
            DEFROST: begin
                if (r_tmr == DFR_LAST) begin
                    w_state_nxt = OFF_HOLD;
                    w_tmr_nxt   = '0;
                    w_dfr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            OFF_HOLD: begin
                if (r_tmr == OFF_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Power loss wins over every transition; the defrost accumulator survives it.
        if (!i_pwr) begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
            w_seg_nxt   = '0;
            w_tmr_nxt   = '0;
            w_dfr_nxt   = r_dfr_acc;
            if ((r_state == COOL_FG) || (r_state == COOL_FR))
                w_last_fr_nxt = w_in_fr;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_fg_dem  <= 1'b0;
            r_fr_dem  <= 1'b0;
            r_last_fr <= 1'b0;
            r_run_cnt <= '0;
            r_seg_cnt <= '0;
            r_tmr     <= '0;
            r_dfr_acc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fg_dem  <= w_fg_dem_nxt;
            r_fr_dem  <= w_fr_dem_nxt;
            r_last_fr <= w_last_fr_nxt;
            r_run_cnt <= w_run_nxt;
            r_seg_cnt <= w_seg_nxt;
            r_tmr     <= w_tmr_nxt;
            r_dfr_acc <= w_dfr_nxt;
        end
    end

    assign o_comp_on   = (r_state == COOL_FG) || (r_state == COOL_FR);
    assign o_damper    = (r_state == COOL_FR);
    assign o_heater_on = (r_state == DEFROST);
    assign o_fg_dem    = r_fg_dem;
    assign o_fr_dem    = r_fr_dem;
    assign o_state     = r_state;

endmodule
